// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline (load-use, taken branch, data-memory wait).
// Optional build macro HAZ_NO_FWD_EN: no-forwarding interlock against DE, EM and MW writers.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       fd_rs1_i,
    input  logic [4:0]       fd_rs2_i,
    input  logic             fd_use_rs1_i,
    input  logic             fd_use_rs2_i,
    input  logic [4:0]       de_rd_i,
    input  logic             de_reg_write_i,
    input  logic             de_mem_read_i,
    input  logic [4:0]       em_rd_i,
    input  logic             em_reg_write_i,
    input  logic [4:0]       mw_rd_i,
    input  logic             mw_reg_write_i,
    input  logic             em_pc_select_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_stall_o,
    output logic             fd_stall_o,
    output logic             fd_flush_o,
    output logic             de_stall_o,
    output logic             de_flush_o,
    output logic             em_stall_o,
    output logic             em_flush_o,
    output logic             mw_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic             mem_err_o
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd2;
    localparam logic [1:0] ST_FLUSH      = 2'd3;

    logic [1:0]       r_state;
    logic [TO_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_mem_err;

    logic [1:0] w_next;
    logic       w_de_hit;
    logic       w_load_use;
    logic       w_raw;
    logic       w_mem_hold;
    logic       w_timeout;
    logic       w_err_set;
    logic       w_pc_stall, w_fd_stall, w_fd_flush, w_de_stall;
    logic       w_de_flush, w_em_stall, w_em_flush, w_mw_bubble;

    // A writer with rd=x0 never creates a dependency.
    assign w_de_hit = de_reg_write_i && (de_rd_i != 5'd0) &&
                      ((fd_use_rs1_i && (fd_rs1_i == de_rd_i)) ||
                       (fd_use_rs2_i && (fd_rs2_i == de_rd_i)));
    assign w_load_use = de_mem_read_i && w_de_hit;

`ifdef HAZ_NO_FWD_EN
    logic w_em_hit;
    logic w_mw_hit;
    assign w_em_hit = em_reg_write_i && (em_rd_i != 5'd0) &&
                      ((fd_use_rs1_i && (fd_rs1_i == em_rd_i)) ||
                       (fd_use_rs2_i && (fd_rs2_i == em_rd_i)));
    assign w_mw_hit = mw_reg_write_i && (mw_rd_i != 5'd0) &&
                      ((fd_use_rs1_i && (fd_rs1_i == mw_rd_i)) ||
                       (fd_use_rs2_i && (fd_rs2_i == mw_rd_i)));
    assign w_raw = w_load_use || w_de_hit || w_em_hit || w_mw_hit;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{em_rd_i, em_reg_write_i, mw_rd_i, mw_reg_write_i};
    assign w_raw = w_load_use;
`endif

    assign w_mem_hold = dmem_req_i && !dmem_ready_i;
    assign w_timeout  = (r_wait_cnt == TO_W'(MEM_TIMEOUT));

    always_comb begin
        w_next      = ST_RUN;
        w_err_set   = 1'b0;
        w_pc_stall  = 1'b0;
        w_fd_stall  = 1'b0;
        w_fd_flush  = 1'b0;
        w_de_stall  = 1'b0;
        w_de_flush  = 1'b0;
        w_em_stall  = 1'b0;
        w_em_flush  = 1'b0;
        w_mw_bubble = 1'b0;
        case (r_state)
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    w_next = ST_RUN;
                end else if (w_timeout) begin
                    // Give up on the access: drop it from EM and keep MW from writing back.
                    w_err_set   = 1'b1;
                    w_em_flush  = 1'b1;
                    w_mw_bubble = 1'b1;
                    w_next      = ST_RUN;
                end else begin
                    w_pc_stall  = 1'b1;
                    w_fd_stall  = 1'b1;
                    w_de_stall  = 1'b1;
                    w_em_stall  = 1'b1;
                    w_mw_bubble = 1'b1;
                    w_next      = ST_MEM_WAIT;
                end
            end
            default: begin
                if (w_mem_hold) begin
                    w_pc_stall  = 1'b1;
                    w_fd_stall  = 1'b1;
                    w_de_stall  = 1'b1;
                    w_em_stall  = 1'b1;
                    w_mw_bubble = 1'b1;
                    w_next      = ST_MEM_WAIT;
                end else if (em_pc_select_i && (r_state != ST_FLUSH)) begin
                    w_fd_flush = 1'b1;
                    w_de_flush = 1'b1;
                    w_em_flush = 1'b1;
                    w_next     = ST_FLUSH;
                end else if (w_raw) begin
                    w_pc_stall = 1'b1;
                    w_fd_stall = 1'b1;
                    w_de_flush = 1'b1;
                    w_next     = ST_LOAD_STALL;
                end
            end
        endcase
    end

    assign pc_stall_o    = w_pc_stall  && !reset_i;
    assign fd_stall_o    = w_fd_stall  && !reset_i;
    assign fd_flush_o    = w_fd_flush  && !reset_i;
    assign de_stall_o    = w_de_stall  && !reset_i;
    assign de_flush_o    = w_de_flush  && !reset_i;
    assign em_stall_o    = w_em_stall  && !reset_i;
    assign em_flush_o    = w_em_flush  && !reset_i;
    assign mw_bubble_o   = w_mw_bubble && !reset_i;
    assign state_o       = r_state;
    assign stall_count_o = r_stall_cnt;
    assign mem_err_o     = r_mem_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_MEM_WAIT) begin
                r_wait_cnt <= (r_state == ST_MEM_WAIT) ? r_wait_cnt + 1'b1 : TO_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table from RUN plus multi-cycle sequences.
// Expectations follow HAZ_NO_FWD_EN when the bench is built with that macro.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 5;
    localparam int TO_W        = 8;
    localparam int MEM_TIMEOUT = 8;

`ifdef HAZ_NO_FWD_EN
    localparam logic NOFWD = 1'b1;
`else
    localparam logic NOFWD = 1'b0;
`endif

    // Output bundle order: pc_stall fd_stall fd_flush de_stall de_flush em_stall em_flush mw_bubble
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_FL   = 8'b0010_1010;
    localparam logic [7:0] O_MEM  = 8'b1101_0101;
    localparam logic [7:0] O_TO   = 8'b0000_0011;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [4:0]       fd_rs1_i, fd_rs2_i, de_rd_i, em_rd_i, mw_rd_i;
    logic             fd_use_rs1_i, fd_use_rs2_i, de_reg_write_i, de_mem_read_i;
    logic             em_reg_write_i, mw_reg_write_i, em_pc_select_i, dmem_req_i, dmem_ready_i;
    logic             pc_stall_o, fd_stall_o, fd_flush_o, de_stall_o;
    logic             de_flush_o, em_stall_o, em_flush_o, mw_bubble_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_count_o;
    logic             mem_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl #(
        .CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fd_rs1_i(fd_rs1_i), .fd_rs2_i(fd_rs2_i),
        .fd_use_rs1_i(fd_use_rs1_i), .fd_use_rs2_i(fd_use_rs2_i),
        .de_rd_i(de_rd_i), .de_reg_write_i(de_reg_write_i), .de_mem_read_i(de_mem_read_i),
        .em_rd_i(em_rd_i), .em_reg_write_i(em_reg_write_i),
        .mw_rd_i(mw_rd_i), .mw_reg_write_i(mw_reg_write_i),
        .em_pc_select_i(em_pc_select_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_stall_o(pc_stall_o), .fd_stall_o(fd_stall_o), .fd_flush_o(fd_flush_o),
        .de_stall_o(de_stall_o), .de_flush_o(de_flush_o), .em_stall_o(em_stall_o),
        .em_flush_o(em_flush_o), .mw_bubble_o(mw_bubble_o),
        .state_o(state_o), .stall_count_o(stall_count_o), .mem_err_o(mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] de_rd;
        logic       de_rw;
        logic       de_mr;
        logic [4:0] em_rd;
        logic       em_rw;
        logic [4:0] mw_rd;
        logic       mw_rw;
        logic       pc_sel;
        logic       req;
        logic       rdy;
        logic [7:0] exp_out;
        logic [1:0] exp_ns;
    } vec_t;

    localparam int NV = 15;
    vec_t  vecs  [NV];
    string names [NV];

    function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] de_rd, input logic de_rw,
                                input logic de_mr, input logic [4:0] em_rd, input logic em_rw,
                                input logic [4:0] mw_rd, input logic mw_rw, input logic pc_sel,
                                input logic req, input logic rdy, input logic [7:0] eo,
                                input logic [1:0] ens);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.de_rd = de_rd; v.de_rw = de_rw; v.de_mr = de_mr;
        v.em_rd = em_rd; v.em_rw = em_rw; v.mw_rd = mw_rd; v.mw_rw = mw_rw;
        v.pc_sel = pc_sel; v.req = req; v.rdy = rdy;
        v.exp_out = eo; v.exp_ns = ens;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {pc_stall_o, fd_stall_o, fd_flush_o, de_stall_o,
                de_flush_o, em_stall_o, em_flush_o, mw_bubble_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        fd_rs1_i = v.rs1; fd_use_rs1_i = v.u1; fd_rs2_i = v.rs2; fd_use_rs2_i = v.u2;
        de_rd_i = v.de_rd; de_reg_write_i = v.de_rw; de_mem_read_i = v.de_mr;
        em_rd_i = v.em_rd; em_reg_write_i = v.em_rw;
        mw_rd_i = v.mw_rd; mw_reg_write_i = v.mw_rw;
        em_pc_select_i = v.pc_sel; dmem_req_i = v.req; dmem_ready_i = v.rdy;
    endtask

    task automatic idle();
        drive(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                 1'b0, 1'b0, 1'b0, O_NONE, 2'd0));
    endtask

    // Advance to just after the next rising edge; inputs change here, outputs are sampled 4 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] exp);
        #4;
        chk(name, {24'd0, outs()}, {24'd0, exp});
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    vec_t v_lu, v_br_lu, v_mem, v_dbub, v_br;

    initial begin
        reset_i = 1'b1;
        idle();

        // Common stimulus: lw x5 in DE, add x6,x5,x1 in FD.
        v_lu    = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                     1'b0, 1'b0, 1'b0, O_LU, 2'd1);
        v_br_lu = v_lu;  v_br_lu.pc_sel = 1'b1;
        v_mem   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                     1'b0, 1'b1, 1'b0, O_MEM, 2'd2);
        v_dbub  = v_lu;  v_dbub.de_rw = 1'b0; v_dbub.de_mr = 1'b0;
        v_br    = v_dbub; v_br.pc_sel = 1'b1;

        names[0]  = "vec_idle";
        vecs[0]   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                       1'b0, 1'b0, 1'b0, O_NONE, 2'd0);
        names[1]  = "vec_load_use_rs1";
        vecs[1]   = v_lu;
        names[2]  = "vec_load_use_rs2";
        vecs[2]   = mk(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                       1'b0, 1'b0, 1'b0, O_LU, 2'd1);
        names[3]  = "vec_load_x0";
        vecs[3]   = mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                       1'b0, 1'b0, 1'b0, O_NONE, 2'd0);
        names[4]  = "vec_load_rs1_unused";
        vecs[4]   = mk(5'd5, 1'b0, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                       1'b0, 1'b0, 1'b0, O_NONE, 2'd0);
        names[5]  = "vec_de_alu_writer";
        vecs[5]   = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                       1'b0, 1'b0, 1'b0, NOFWD ? O_LU : O_NONE, NOFWD ? 2'd1 : 2'd0);
        names[6]  = "vec_load_no_regwrite";
        vecs[6]   = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                       1'b0, 1'b0, 1'b0, O_NONE, 2'd0);
        names[7]  = "vec_branch";
        vecs[7]   = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                       1'b1, 1'b0, 1'b0, O_FL, 2'd3);
        names[8]  = "vec_branch_over_load_use";
        vecs[8]   = v_br_lu; vecs[8].exp_out = O_FL; vecs[8].exp_ns = 2'd3;
        names[9]  = "vec_mem_hold";
        vecs[9]   = v_mem;
        names[10] = "vec_mem_over_all";
        vecs[10]  = v_br_lu; vecs[10].req = 1'b1; vecs[10].exp_out = O_MEM; vecs[10].exp_ns = 2'd2;
        names[11] = "vec_mem_ready_same_cycle";
        vecs[11]  = v_mem; vecs[11].rdy = 1'b1; vecs[11].exp_out = O_NONE; vecs[11].exp_ns = 2'd0;
        names[12] = "vec_mw_writer_x7";
        vecs[12]  = mk(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1,
                       1'b0, 1'b0, 1'b0, NOFWD ? O_LU : O_NONE, NOFWD ? 2'd1 : 2'd0);
        names[13] = "vec_em_writer_x9";
        vecs[13]  = mk(5'd1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0,
                       1'b0, 1'b0, 1'b0, NOFWD ? O_LU : O_NONE, NOFWD ? 2'd1 : 2'd0);
        names[14] = "vec_mw_writer_x0";
        vecs[14]  = mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1,
                       1'b0, 1'b0, 1'b0, O_NONE, 2'd0);

        // Reset with every hazard present: outputs must stay low and registers clear.
        drive(v_br_lu);
        dmem_req_i = 1'b1;
        tick();
        chk_out("reset_outputs_low", O_NONE);
        chk("reset_state", {30'd0, state_o}, 32'd0);
        chk("reset_stall_count", {27'd0, stall_count_o}, 32'd0);
        chk("reset_mem_err", {31'd0, mem_err_o}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            drive(vecs[i]);
            chk_out({names[i], "_out"}, vecs[i].exp_out);
            tick();
            chk({names[i], "_next_state"}, {30'd0, state_o}, {30'd0, vecs[i].exp_ns});
        end

        // Load-use: one stall cycle, then the bubble in DE releases the pipeline.
        do_reset();
        drive(v_lu);
        chk_out("lu_seq_stall", O_LU);
        tick();
        chk("lu_seq_state1", {30'd0, state_o}, 32'd1);
        drive(v_dbub);
        chk_out("lu_seq_release", O_NONE);
        tick();
        chk("lu_seq_state_run", {30'd0, state_o}, 32'd0);
        chk("lu_seq_count", {27'd0, stall_count_o}, 32'd1);

        // Branch + load-use, then FLUSH ignores a still-asserted em_pc_select.
        do_reset();
        drive(v_br_lu);
        chk_out("br_seq_flush", O_FL);
        tick();
        chk("br_seq_state3", {30'd0, state_o}, 32'd3);
        drive(v_br);
        chk_out("br_seq_flush_ignores_sel", O_NONE);
        tick();
        chk("br_seq_state_run", {30'd0, state_o}, 32'd0);
        chk("br_seq_count", {27'd0, stall_count_o}, 32'd0);

        // Branch arriving while in LOAD_STALL.
        do_reset();
        drive(v_lu);
        tick();
        drive(v_br);
        chk_out("ls_branch_flush", O_FL);
        tick();
        chk("ls_branch_state3", {30'd0, state_o}, 32'd3);

        // Memory hold beginning in FLUSH.
        do_reset();
        drive(vecs[7]);
        tick();
        drive(v_mem);
        chk_out("flush_mem_hold", O_MEM);
        tick();
        chk("flush_mem_state2", {30'd0, state_o}, 32'd2);

        // Memory wait: ready low for 4 cycles, release on the ready cycle.
        do_reset();
        drive(v_mem);
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("memwait_freeze_%0d", i), O_MEM);
            tick();
        end
        chk("memwait_state2", {30'd0, state_o}, 32'd2);
        em_pc_select_i = 1'b1;
        dmem_ready_i   = 1'b1;
        chk_out("memwait_release", O_NONE);
        tick();
        chk("memwait_state_run", {30'd0, state_o}, 32'd0);
        chk("memwait_count", {27'd0, stall_count_o}, 32'd4);
        dmem_req_i = 1'b0;
        chk_out("memwait_branch_after_exit", O_FL);
        tick();
        chk("memwait_branch_state3", {30'd0, state_o}, 32'd3);

        // Timeout: ready never comes; 8 frozen cycles then a drop pulse.
        do_reset();
        drive(v_mem);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            chk_out($sformatf("timeout_freeze_%0d", i), O_MEM);
            tick();
        end
        chk("timeout_err_not_yet", {31'd0, mem_err_o}, 32'd0);
        chk_out("timeout_pulse", O_TO);
        tick();
        chk("timeout_state_run", {30'd0, state_o}, 32'd0);
        chk("timeout_mem_err", {31'd0, mem_err_o}, 32'd1);
        chk("timeout_count", {27'd0, stall_count_o}, 32'd8);
        idle();
        tick();
        chk("timeout_err_sticky", {31'd0, mem_err_o}, 32'd1);

        // Reset during MEM_WAIT.
        drive(v_mem);
        tick();
        tick();
        chk("midwait_state2", {30'd0, state_o}, 32'd2);
        reset_i = 1'b1;
        chk_out("midwait_reset_outputs", O_NONE);
        tick();
        reset_i = 1'b0;
        idle();
        chk("midwait_reset_state", {30'd0, state_o}, 32'd0);
        chk("midwait_reset_count", {27'd0, stall_count_o}, 32'd0);
        chk("midwait_reset_err", {31'd0, mem_err_o}, 32'd0);

        // Reset during LOAD_STALL.
        drive(v_lu);
        tick();
        chk("midls_state1", {30'd0, state_o}, 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        idle();
        chk("midls_reset_state", {30'd0, state_o}, 32'd0);
        chk("midls_reset_count", {27'd0, stall_count_o}, 32'd0);

        // Persistent load-use: stays in LOAD_STALL and the counter saturates at 31.
        do_reset();
        drive(v_lu);
        for (int i = 0; i < 40; i++) tick();
        chk("sat_state1", {30'd0, state_o}, 32'd1);
        chk("sat_count", {27'd0, stall_count_o}, 32'd31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RV32 pipeline.
- Watches decode operands, the execute-stage load, the resolved branch in the EX/MEM register and the data-memory handshake.
- Drives per-register stall/flush enables for PC, FD, DE and EM, plus a bubble into MW.
- Data forwarding muxes are outside this block; it only sequences the pipeline.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter
TO_W, 8, width of memory-wait timeout counter
MEM_TIMEOUT, 255, maximum consecutive wait cycles before error (must fit in TO_W)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
fd_rs1_i  in  5  rs1 of instruction in FD register
fd_rs2_i  in  5  rs2 of instruction in FD register
fd_use_rs1_i  in  1  FD instruction reads rs1
fd_use_rs2_i  in  1  FD instruction reads rs2
de_rd_i  in  5  rd in DE register
de_reg_write_i  in  1  DE instruction writes rd
de_mem_read_i  in  1  DE instruction is a load
em_rd_i  in  5  rd in EM register (used only with HAZ_NO_FWD_EN)
em_reg_write_i  in  1  EM writes rd (used only with HAZ_NO_FWD_EN)
mw_rd_i  in  5  rd in MW register (used only with HAZ_NO_FWD_EN)
mw_reg_write_i  in  1  MW writes rd (used only with HAZ_NO_FWD_EN)
em_pc_select_i  in  1  branch/jump taken, from EM register
dmem_req_i  in  1  memory stage issuing load/store this cycle
dmem_ready_i  in  1  data memory completes access this cycle
pc_stall_o  out  1  hold PC
fd_stall_o  out  1  hold FD register
fd_flush_o  out  1  load NOP into FD
de_stall_o  out  1  hold DE register
de_flush_o  out  1  load bubble (all controls 0) into DE
em_stall_o  out  1  hold EM register
em_flush_o  out  1  load bubble into EM
mw_bubble_o  out  1  load bubble into MW (no reg_write)
state_o  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT, 3 FLUSH
stall_count_o  out  CNT_W  cycles with pc_stall_o=1, saturating
mem_err_o  out  1  sticky memory-timeout error

Behaviour:
Outputs and reset:
- Control outputs are Mealy: combinational from the current state and inputs, effective at the next clk_i edge.
- Reset: state is RUN, counters are 0, mem_err_o is 0. During reset all stall/flush outputs are 0.
- Hazard match: register index 0 never causes a hazard. Match means use_rsX && (rsX == rd) && rd != 0 && reg_write.
- load_use = de_mem_read_i && de_reg_write_i && match(de_rd_i).
- mem_hold = dmem_req_i && !dmem_ready_i.

Priority in RUN, LOAD_STALL and FLUSH (highest first):
1) mem_hold: pc/fd/de/em stall=1, mw_bubble=1; next MEM_WAIT; wait counter loads 1.
2) em_pc_select_i, evaluated in RUN and LOAD_STALL only: fd/de/em flush=1, no stalls; next FLUSH.
3) load_use: pc_stall=1, fd_stall=1, de_flush=1; next LOAD_STALL.
4) Otherwise all outputs 0; next RUN.

FLUSH:
- Exactly one cycle. em_pc_select_i is ignored, since EM now holds a bubble.
- load_use cannot occur because DE is a bubble.
- Next state is RUN unless mem_hold.

MEM_WAIT:
- Freeze outputs stay asserted while dmem_ready_i=0; the wait counter increments each cycle.
- On dmem_ready_i=1, all outputs drop to 0 that same cycle and the pipeline advances. Then next RUN.
- A taken branch held in the frozen EM is serviced in the first RUN cycle after exit.
- If the wait counter reaches MEM_TIMEOUT with ready still 0: set mem_err_o, force exit to RUN with mw_bubble_o=1 and em_flush_o=1, dropping the access.
- mem_err_o clears only on reset_i.

Counters and simultaneous events:
- stall_count_o increments on every cycle with pc_stall_o=1 and saturates at all-ones.
- Branch together with load_use: the branch wins; the flush removes the consumer.
- Reset asserted mid-MEM_WAIT or mid-LOAD_STALL: next cycle is RUN with counters 0.

Optional Feature:
HAZ_NO_FWD_EN:
- Defined: the pipeline runs without forwarding. The RAW interlock (priority 3) also matches against em_rd_i/em_reg_write_i and mw_rd_i/mw_reg_write_i, so any pending writer in DE, EM or MW stalls decode with the same pc/fd stall and de_flush.
- The stall repeats each cycle, staying in LOAD_STALL, until no writer matches.
- Undefined: only the DE load-use check applies; the em_*/mw_* rd ports are ignored.

Test Plan:
- Load-use: DE lw x5 (mem_read=1, rd=5), FD add x6,x5,x1 -> one cycle pc_stall=fd_stall=de_flush=1, state 1, then RUN; stall_count_o=1.
- rd=x0 load with FD rs1=0 -> no stall, all outputs 0.
- Taken branch: em_pc_select_i=1 with a simultaneous load_use -> fd/de/em flush=1, no stall, state 3 for one cycle, em_pc_select_i=1 in FLUSH ignored.
- Memory wait: dmem_req_i=1, ready low 4 cycles -> pc/fd/de/em stall=1 and mw_bubble=1 for 4 cycles, release on the ready cycle, stall_count_o=4.
- Timeout with MEM_TIMEOUT=8, ready never asserted -> mem_err_o=1 after 8 wait cycles, em_flush/mw_bubble pulse, RUN. Reset mid-wait -> RUN, counters 0.
- With HAZ_NO_FWD_EN, MW writes x7 and FD reads x7 -> one stall cycle. Without the macro -> no stall.
